// File: rtl/vote_collector.sv
// Collects one yes/no vote from each of four voters and presents the ballot to a 4-input majority voter.
// A session closes on the fourth distinct vote or after TMO collect cycles; repeat votes are rejected.
module vote_collector #(
   parameter int unsigned TMO = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       vote_vld,
   input  logic [1:0] vote_id,
   input  logic       vote_val,
   output logic [3:0] ballot,
   output logic       ballot_vld,
   input  logic       ballot_rdy,
   output logic [3:0] voted,
   output logic       busy,
   output logic       dup_err,
   output logic       timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TMO - 32'd1);

   state_t      state_r;
   state_t      state_s;
   logic [15:0] timer_r;
   logic [15:0] timer_s;
   logic [3:0]  ballot_s;
   logic [3:0]  voted_s;
   logic        dup_s;
   logic        tmo_s;
   logic        vld_s;
   logic        busy_s;

   // Next-state and next-output logic.
   always_comb begin
      state_s  = state_r;
      timer_s  = timer_r;
      ballot_s = ballot;
      voted_s  = voted;
      dup_s    = 1'b0;
      tmo_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s  = COLLECT;
               timer_s  = 16'd0;
               ballot_s = 4'b0000;
               voted_s  = 4'b0000;
            end else begin
               state_s = IDLE;
            end
         end
         COLLECT: begin
            timer_s = timer_r + 16'd1;
            if (vote_vld) begin
               if (voted[vote_id]) begin
                  dup_s = 1'b1;
               end else begin
                  voted_s[vote_id]  = 1'b1;
                  ballot_s[vote_id] = vote_val;
               end
            end else begin
               dup_s = 1'b0;
            end
            // Completion is checked first so a fourth vote on the last cycle is not a timeout.
            if (voted_s == 4'b1111) begin
               state_s = HOLD;
            end else if (timer_r == TMO_LAST) begin
               state_s = HOLD;
               tmo_s   = 1'b1;
            end else begin
               state_s = COLLECT;
            end
         end
         HOLD: begin
            if (ballot_rdy) begin
               state_s = IDLE;
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      vld_s  = (state_s == HOLD);
      busy_s = (state_s != IDLE);
   end

   // State, timer and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         timer_r    <= 16'd0;
         ballot     <= 4'b0000;
         voted      <= 4'b0000;
         ballot_vld <= 1'b0;
         busy       <= 1'b0;
         dup_err    <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state_r    <= state_s;
         timer_r    <= timer_s;
         ballot     <= ballot_s;
         voted      <= voted_s;
         ballot_vld <= vld_s;
         busy       <= busy_s;
         dup_err    <= dup_s;
         timeout    <= tmo_s;
      end
   end

endmodule
